pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage pipeline; drives IF_ID write-enable (hd) and flush.
//  Detects load-use hazards, applies taken-branch/jump flushes, freezes the whole pipe during
//  multi-cycle data-memory accesses (req/ack), counts stall cycles, flags stuck memory (timeout).
// PARAMETERS
//  MEM_TIMEOUT  255  max MEM_WAIT cycles before err_timeout_o sets (1..2^CNT_W-1)
//  CNT_W        16   width of stall-cycle counter and timeout counter
// PORTS
//  clk_i            in   1      clock, rising edge
//  rst_i            in   1      asynchronous, active-low reset
//  ifid_rs_i        in   5      rs field of instruction in IF_ID
//  ifid_rt_i        in   5      rt field of instruction in IF_ID
//  idex_memread_i   in   1      instruction in ID_EX is a load
//  idex_rt_i        in   5      destination rt of instruction in ID_EX
//  branch_taken_i   in   1      branch resolved taken in ID this cycle
//  jump_i           in   1      jump decoded in ID this cycle
//  dmem_req_i       in   1      EX_MEM instruction starts a data-memory access
//  dmem_ack_i       in   1      data memory completes access this cycle
//  pc_write_o       out  1      PC update enable
//  ifid_write_o     out  1      IF_ID load enable (hd); 0 = hold
//  ifid_flush_o     out  1      IF_ID loads NOP (0x0000_0000) at next edge
//  idex_bubble_o    out  1      ID_EX control fields forced to 0 at next edge
//  pipe_hold_o      out  1      ID_EX, EX_MEM, MEM_WB hold contents
//  state_o          out  2      FSM state: 00 RUN, 01 LU_STALL, 10 MEM_WAIT
//  stall_cnt_o      out  CNT_W  total stall cycles since reset, saturating
//  err_timeout_o    out  1      sticky: MEM_WAIT exceeded MEM_TIMEOUT
// BEHAVIOUR
//  Reset (rst_i=0, async): state=RUN, stall_cnt_o=0, wait_cnt=0, err_timeout_o=0.
//   Outputs during reset: pc_write_o=1, ifid_write_o=1, others 0.
//  lu_hazard = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
//  Outputs are combinational from state + inputs (same-cycle effect); state/counters registered.
//  RUN:
//   - dmem_req_i & ~dmem_ack_i -> next MEM_WAIT; this cycle pc_write_o=0, ifid_write_o=0,
//     pipe_hold_o=1, no flush/bubble. req with ack same cycle = 1-cycle access, stay RUN, no stall.
//   - else lu_hazard -> next LU_STALL; this cycle pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
//     Flush suppressed (branch may depend on load; re-evaluated after stall).
//   - else (branch_taken_i|jump_i) -> ifid_flush_o=1, pc/ifid write=1, state stays RUN.
//   - else all enables 1, flush/bubble/hold 0.
//  LU_STALL: exactly one cycle; outputs as RUN evaluated on current inputs (hazard now cleared);
//   next RUN, or MEM_WAIT if dmem_req_i & ~dmem_ack_i.
//  MEM_WAIT: pc_write_o=0, ifid_write_o=0, pipe_hold_o=1, flush/bubble=0; branch/lu ignored.
//   dmem_ack_i=1 -> hold still asserted this cycle, next RUN; wait_cnt cleared.
//   wait_cnt increments per MEM_WAIT cycle; at wait_cnt==MEM_TIMEOUT set err_timeout_o (sticky to
//   reset); FSM keeps waiting for ack (no abort).
//  Priority: MEM_WAIT/memory freeze > load-use stall > flush. Never flush and stall same cycle.
//  stall_cnt_o += 1 on every cycle with pc_write_o=0; saturates at 2^CNT_W-1, no wrap.
//  Reset asserted mid-MEM_WAIT or LU_STALL: immediate return to RUN, counters cleared.
//  state encoding 11 unreachable; if entered, next state RUN.
// TESTING
//  1 Reset then idle inputs -> state_o=00, pc_write_o=1, ifid_write_o=1, stall_cnt_o=0.
//  2 idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> 1 cycle ifid_write_o=0, idex_bubble_o=1,
//    state 01, then RUN; stall_cnt_o=1. Same with idex_rt_i=0 -> no stall.
//  3 branch_taken_i=1, no hazard -> ifid_flush_o=1 for 1 cycle; with lu_hazard same cycle ->
//    flush=0, bubble=1.
//  4 dmem_req_i=1, ack after 4 cycles -> pipe_hold_o=1 for 4 cycles, state 10, stall_cnt_o=4;
//    req+ack same cycle -> no stall.
//  5 MEM_TIMEOUT=3, ack never -> err_timeout_o=1 after 3 MEM_WAIT cycles, stays 1 after ack.
//  6 rst_i=0 mid MEM_WAIT (async, between edges) -> state_o=00, counters 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls, branch/jump
// flushes, whole-pipe freeze during multi-cycle data-memory accesses, stall and timeout tracking.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_timeout_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             lu_hazard;
  logic             mem_stall;

  assign lu_hazard = idex_memread_i && (idex_rt_i != 5'd0) &&
                     ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  assign mem_stall = dmem_req_i && !dmem_ack_i;

  // LU_STALL reuses the RUN decision but never re-stalls: the bubble already separated the load.
  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    state_next    = RUN;
    if (rst_i) begin
      case (state)
        MEM_WAIT: begin
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          pipe_hold_o  = 1'b1;
          state_next   = dmem_ack_i ? RUN : MEM_WAIT;
        end
        RUN, LU_STALL: begin
          if (mem_stall) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
            state_next   = MEM_WAIT;
          end else if (lu_hazard && (state == RUN)) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            state_next    = LU_STALL;
          end else if (branch_taken_i || jump_i) begin
            ifid_flush_o = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= RUN;
      stall_cnt_o   <= '0;
      wait_cnt      <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      state <= state_next;
      if (!pc_write_o && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      // The error flag sets on the edge that completes the MEM_TIMEOUT-th unacknowledged wait cycle.
      if ((state == MEM_WAIT) && !dmem_ack_i) begin
        if (wait_cnt != CNT_MAX) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        if (wait_cnt >= TIMEOUT_LAST) begin
          err_timeout_o <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 5;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst_i;
  logic [4:0]    ifid_rs, ifid_rt, idex_rt;
  logic          idex_memread, branch_taken, jump, dmem_req, dmem_ack;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, err_timeout;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  // reference model: mode 0 running, 1 just stalled for a load, 2 waiting on memory
  int m_mode;
  int m_stalls;
  int m_waits;
  bit m_err;
  bit e_pc, e_ifw, e_flush, e_bub, e_hold;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt),
    .idex_memread_i(idex_memread), .idex_rt_i(idex_rt),
    .branch_taken_i(branch_taken), .jump_i(jump),
    .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .pipe_hold_o(pipe_hold), .state_o(state),
    .stall_cnt_o(stall_cnt), .err_timeout_o(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit loadUse();
    return idex_memread && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
  endfunction

  task automatic modelReset();
    m_mode = 0; m_stalls = 0; m_waits = 0; m_err = 0;
  endtask

  task automatic modelOutputs();
    bit freeze, stall;
    freeze = rst_i && (m_mode == 2 || (dmem_req && !dmem_ack));
    stall  = rst_i && !freeze && m_mode == 0 && loadUse();
    e_hold  = freeze;
    e_bub   = stall;
    e_pc    = !(freeze || stall);
    e_ifw   = e_pc;
    e_flush = rst_i && !freeze && !stall && (branch_taken || jump);
  endtask

  task automatic checkAll(input string tag);
    modelOutputs();
    checkOutput({tag, ".pc_write"}, pc_write, e_pc);
    checkOutput({tag, ".ifid_write"}, ifid_write, e_ifw);
    checkOutput({tag, ".flush"}, ifid_flush, e_flush);
    checkOutput({tag, ".bubble"}, idex_bubble, e_bub);
    checkOutput({tag, ".hold"}, pipe_hold, e_hold);
    checkOutput({tag, ".state"}, state, m_mode);
    checkOutput({tag, ".stall_cnt"}, stall_cnt, m_stalls);
    checkOutput({tag, ".err"}, err_timeout, m_err);
  endtask

  // what the edge closing the current cycle does to the model
  task automatic modelAdvance();
    int next_mode;
    modelOutputs();
    if (m_mode == 2)                 next_mode = dmem_ack ? 0 : 2;
    else if (dmem_req && !dmem_ack)  next_mode = 2;
    else if (m_mode == 0 && loadUse()) next_mode = 1;
    else                             next_mode = 0;
    if (!e_pc && m_stalls < SAT) m_stalls++;
    if (m_mode == 2 && !dmem_ack) begin
      m_waits++;
      if (m_waits >= TO) m_err = 1;
    end else begin
      m_waits = 0;
    end
    m_mode = next_mode;
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input bit mr,
                               input logic [4:0] xrt, input bit br, input bit jp,
                               input bit rq, input bit ak, input string tag);
    @(posedge clk);
    #1;
    ifid_rs = rs; ifid_rt = rt; idex_memread = mr; idex_rt = xrt;
    branch_taken = br; jump = jp; dmem_req = rq; dmem_ack = ak;
    #2;
    checkAll(tag);
    modelAdvance();
  endtask

  task automatic idle(input string tag);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // asynchronous reset dropped between edges, held across one edge
  task automatic doReset(input string tag);
    #1;
    ifid_rs = 0; ifid_rt = 0; idex_memread = 0; idex_rt = 0;
    branch_taken = 0; jump = 0; dmem_req = 0; dmem_ack = 0;
    rst_i = 1'b0;
    #1;
    modelReset();
    checkAll(tag);
    @(posedge clk);
    #2;
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0;
    ifid_rs = 0; ifid_rt = 0; idex_memread = 0; idex_rt = 0;
    branch_taken = 0; jump = 0; dmem_req = 0; dmem_ack = 0;
    modelReset();
    #2;
    checkAll("reset");
    #20;
    rst_i = 1'b1;

    idle("idle");
    // load-use on rs, then stall cycle, then back to run
    applyStimulus(5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, "lu_rs");
    idle("lu_after");
    idle("lu_run");
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_r0");
    applyStimulus(5'd4, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, "lu_rt");
    // branch flush alone, then branch together with a hazard
    applyStimulus(5'd4, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, "branch");
    applyStimulus(5'd4, 5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, "jump");
    applyStimulus(5'd7, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, "br_lu");
    applyStimulus(5'd7, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, "br_lu_after");
    // memory access acknowledged on the fourth held cycle
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "mem_req");
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, "mem_w1");
    applyStimulus(5'd1, 5'd2, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, "mem_w2");
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "mem_ack");
    idle("mem_done");
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, "mem_1cyc");
    idle("mem_1cyc_after");
    // stuck memory: timeout and stall counter saturation, flag sticky after ack
    for (int i = 0; i < SAT + 40; i++)
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "stuck");
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "stuck_ack");
    idle("sticky");
    doReset("rst_after_sat");
    idle("post_reset");
    // reset mid memory wait
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "wait_a");
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "wait_b");
    doReset("rst_mid_wait");
    idle("post_reset2");

    for (int i = 0; i < 600; i++) begin
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 99) == 0) doReset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
